// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the simple-CPU sequencers: opcodes, IR field
// positions, FSM state encoding, opcode classes and the control-word payload.
package cpu_ctrl_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned OPC_W = 5;

    // IR field bit positions
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_MSB  = 26;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_MSB  = 22;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_MSB  = 18;
    localparam int unsigned RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALTED
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    // One bit per datapath control line
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic r_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic r_in;
        logic lo_in;
        logic hi_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
    } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode-to-class map shared by the instruction sequencers.
// ALU_SEQ_MULDIV_EN: when undefined, MUL/DIV decode as NOP.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class_c
);

    always_comb begin
        op_class_c = CLS_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class_c = CLS_ALU;
            OP_MUL, OP_DIV: begin
`ifdef ALU_SEQ_MULDIV_EN
                op_class_c = CLS_MULDIV;
`else
                op_class_c = CLS_NOP;
`endif
            end
            OP_HALT: op_class_c = CLS_HALT;
            default: op_class_c = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired T0..T6 control sequencer for register-to-register ALU instructions.
// ALU_SEQ_MULDIV_EN enables the MUL/DIV LO (T5) / HI (T6) writeback path.
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [IR_W-1:0] IR_data,
    input  logic            Stop,
    output logic            Run,
    output logic            PCout,
    output logic            Zlowout,
    output logic            ZHighout,
    output logic            MDRout,
    output logic            Rout,
    output logic            PCin,
    output logic            MARin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Rin,
    output logic            LOin,
    output logic            HIin,
    output logic            IncPC,
    output logic            Read,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic [OPW-1:0]  operation
);

    state_t           state;
    state_t           state_nxt;
    logic             sticky_halt;
    logic             sticky_halt_nxt;
    logic [OPC_W-1:0] opcode;
    op_class_t        op_class;
    ctrl_t            ctrl;
    logic             run_c;
    logic [OPW-1:0]   operation_c;
    logic             unused_ir;

    assign opcode    = IR_data[OPC_MSB:OPC_LSB];
    // Register fields are consumed by the select-and-encode unit, not here
    assign unused_ir = ^{IR_data[RA_MSB:RA_LSB], IR_data[RB_MSB:RB_LSB],
                         IR_data[RC_MSB:RC_LSB], IR_data[RC_LSB-1:0]};

    opcode_class_decode u_class_decode (
        .opcode     (opcode),
        .op_class_c (op_class)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= ST_RESET;
            sticky_halt <= 1'b0;
        end else begin
            state       <= state_nxt;
            sticky_halt <= sticky_halt_nxt;
        end
    end

    // Next state and Moore control decode
    always_comb begin
        state_nxt       = state;
        sticky_halt_nxt = sticky_halt;
        ctrl            = '0;
        run_c           = 1'b0;
        operation_c     = '0;
        case (state)
            ST_RESET: state_nxt = ST_T0;
            ST_T0: begin
                run_c       = 1'b1;
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
                state_nxt   = ST_T1;
            end
            ST_T1: begin
                run_c         = 1'b1;
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
                state_nxt     = ST_T2;
            end
            ST_T2: begin
                run_c        = 1'b1;
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                case (op_class)
                    CLS_ALU, CLS_MULDIV: state_nxt = ST_T3;
                    CLS_HALT: begin
                        state_nxt       = ST_HALTED;
                        sticky_halt_nxt = 1'b1;
                    end
                    default: state_nxt = Stop ? ST_HALTED : ST_T0;
                endcase
            end
            ST_T3: begin
                run_c      = 1'b1;
                ctrl.grb   = 1'b1;
                ctrl.r_out = 1'b1;
                ctrl.y_in  = 1'b1;
                state_nxt  = ST_T4;
            end
            ST_T4: begin
                run_c       = 1'b1;
                ctrl.grc    = 1'b1;
                ctrl.r_out  = 1'b1;
                ctrl.z_in   = 1'b1;
                operation_c = OPW'(opcode);
                state_nxt   = ST_T5;
            end
            ST_T5: begin
                run_c         = 1'b1;
                ctrl.zlow_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (op_class == CLS_MULDIV) begin
                    ctrl.lo_in = 1'b1;
                    state_nxt  = ST_T6;
                end else
`endif
                begin
                    ctrl.gra  = 1'b1;
                    ctrl.r_in = 1'b1;
                    state_nxt = Stop ? ST_HALTED : ST_T0;
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                run_c          = 1'b1;
                ctrl.zhigh_out = 1'b1;
                ctrl.hi_in     = 1'b1;
                state_nxt      = Stop ? ST_HALTED : ST_T0;
            end
`endif
            // A HALT opcode parks here until reset; a Stop request only pauses
            ST_HALTED: begin
                if (!sticky_halt && !Stop) begin
                    state_nxt = ST_T0;
                end
            end
            default: state_nxt = ST_RESET;
        endcase
    end

    assign Run       = run_c;
    assign PCout     = ctrl.pc_out;
    assign Zlowout   = ctrl.zlow_out;
    assign ZHighout  = ctrl.zhigh_out;
    assign MDRout    = ctrl.mdr_out;
    assign Rout      = ctrl.r_out;
    assign PCin      = ctrl.pc_in;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign Rin       = ctrl.r_in;
    assign LOin      = ctrl.lo_in;
    assign HIin      = ctrl.hi_in;
    assign IncPC     = ctrl.inc_pc;
    assign Read      = ctrl.read;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign operation = operation_c;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: per-instruction control-step
// model plus hand-computed control words; honours ALU_SEQ_MULDIV_EN.
module tb_alu_instr_sequencer;

    logic        Clock;
    logic        Resetn;
    logic [31:0] IR_data;
    logic        Stop;
    logic        Run, PCout, Zlowout, ZHighout, MDRout, Rout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin;
    logic        IncPC, Read, Gra, Grb, Grc;
    logic [4:0]  operation;

    alu_instr_sequencer #(.OPW(5)) dut (
        .Clock(Clock), .Resetn(Resetn), .IR_data(IR_data), .Stop(Stop),
        .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .MDRout(MDRout), .Rout(Rout), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
        .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .operation(operation)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [24:0] M_RUN    = 25'h1000000;
    localparam logic [24:0] M_PCOUT  = 25'h0800000;
    localparam logic [24:0] M_ZLOW   = 25'h0400000;
    localparam logic [24:0] M_ZHIGH  = 25'h0200000;
    localparam logic [24:0] M_MDROUT = 25'h0100000;
    localparam logic [24:0] M_ROUT   = 25'h0080000;
    localparam logic [24:0] M_PCIN   = 25'h0040000;
    localparam logic [24:0] M_MARIN  = 25'h0020000;
    localparam logic [24:0] M_MDRIN  = 25'h0010000;
    localparam logic [24:0] M_IRIN   = 25'h0008000;
    localparam logic [24:0] M_YIN    = 25'h0004000;
    localparam logic [24:0] M_ZIN    = 25'h0002000;
    localparam logic [24:0] M_RIN    = 25'h0001000;
    localparam logic [24:0] M_LOIN   = 25'h0000800;
    localparam logic [24:0] M_HIIN   = 25'h0000400;
    localparam logic [24:0] M_INCPC  = 25'h0000200;
    localparam logic [24:0] M_READ   = 25'h0000100;
    localparam logic [24:0] M_GRA    = 25'h0000080;
    localparam logic [24:0] M_GRB    = 25'h0000040;
    localparam logic [24:0] M_GRC    = 25'h0000020;

    typedef struct {
        string       tag;
        logic [24:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [24:0] act();
        return {Run, PCout, Zlowout, ZHighout, MDRout, Rout, PCin, MARin, MDRin,
                IRin, Yin, Zin, Rin, LOin, HIin, IncPC, Read, Gra, Grb, Grc, operation};
    endfunction

    function automatic bit is_alu(input logic [4:0] op);
        return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110,
                          5'b00111, 5'b01001, 5'b01010, 5'b01011};
    endfunction

    function automatic bit is_muldiv(input logic [4:0] op);
`ifdef ALU_SEQ_MULDIV_EN
        return (op == 5'b01111) || (op == 5'b10000);
`else
        return (op == 5'b11111) && (op == 5'b00000);
`endif
    endfunction

    // Active cycles an instruction occupies, fetch included
    function automatic int instr_len(input logic [4:0] op);
        if (is_alu(op))    return 6;
        if (is_muldiv(op)) return 7;
        return 3;
    endfunction

    // Required control word in step k (0 = T0) of an instruction
    function automatic logic [24:0] model_word(input logic [4:0] op, input int k);
        case (k)
            0: return M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
            1: return M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
            2: return M_RUN | M_MDROUT | M_IRIN;
            3: return M_RUN | M_GRB | M_ROUT | M_YIN;
            4: return M_RUN | M_GRC | M_ROUT | M_ZIN | {20'd0, op};
            5: return is_muldiv(op) ? (M_RUN | M_ZLOW | M_LOIN)
                                    : (M_RUN | M_ZLOW | M_GRA | M_RIN);
            6: return M_RUN | M_ZHIGH | M_HIIN;
            default: return 25'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at %0t", tag, got, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic push(input string tag, input logic [24:0] w);
        exp_t e;
        e.tag = tag;
        e.w   = w;
        exp_q.push_back(e);
    endtask

    // Run one whole instruction; Stop is raised in step stop_k (if >= 0)
    task automatic do_instr(input string tag, input logic [31:0] ir, input int stop_k);
        int n;
        n = instr_len(ir[31:27]);
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) IR_data = ir;
            if (k == stop_k) Stop = 1'b1;
            push(tag, model_word(ir[31:27], k));
        end
    endtask

    // Compare process: every cycle with a pending expectation
    always @(negedge Clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, act(), e.w);
        end
    end

    initial begin
        Resetn  = 1'b0;
        Stop    = 1'b0;
        IR_data = 32'd0;

        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) check("reset_outputs", act(), 25'd0);
            if (k == 2) Resetn = 1'b1;
            push("reset", 25'd0);
        end

        // AND R4,R5,R7 with hand-computed words
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) IR_data = 32'h2A2B8000;
            push("and", model_word(5'b00101, k));
            if (k == 0) check("first_t0_lit", act(), 25'h1822200);
            if (k == 3) check("and_t3_lit", act(), 25'h1084040);
            if (k == 4) check("and_t4_lit", act(), 25'h1082025);
            if (k == 5) check("and_t5_lit", act(), 25'h1401080);
        end

        do_instr("add",     32'h18000000, -1);
        do_instr("sub",     32'h21190000, -1);
        do_instr("shl",     32'h4A2B8000, -1);
        do_instr("rol",     32'h59918000, -1);
        do_instr("illegal", 32'h40000000, -1);
        do_instr("nop",     32'hD0000000, -1);

        // MUL with hand-computed tail
        for (int k = 0; k < instr_len(5'b01111); k++) begin
            tick();
            if (k == 0) IR_data = 32'h78880000;
            push("mul", model_word(5'b01111, k));
`ifdef ALU_SEQ_MULDIV_EN
            if (k == 5) check("mul_t5_lit", act(), 25'h1400800);
            if (k == 6) check("mul_t6_lit", act(), 25'h1200400);
`endif
        end
        do_instr("div",       32'h80888000, -1);
        do_instr("after_div", 32'h30000000, -1);

        // Stop raised in T4 of an ADD
        do_instr("add_stop", 32'h18000000, 4);
        tick();
        push("stop_halted", 25'd0);
        check("stop_run_low", {24'd0, Run}, 25'd0);
        tick();
        Stop = 1'b0;
        push("stop_halted", 25'd0);
        do_instr("stop_resume", 32'h38000000, -1);

        // HALT opcode: sticky for 20 cycles, then a reset pulse
        do_instr("halt", 32'hD8000000, -1);
        for (int k = 0; k < 20; k++) begin
            tick();
            push("halt_sticky", 25'd0);
        end
        tick();
        Resetn = 1'b0;
        push("halt_reset", 25'd0);
        tick();
        Resetn = 1'b1;
        push("halt_reset", 25'd0);
        tick();
        IR_data = 32'h50000000;
        push("after_halt", model_word(5'b01010, 0));
        check("after_halt_t0_lit", act(), 25'h1822200);
        for (int k = 1; k < 6; k++) begin
            tick();
            push("after_halt", model_word(5'b01010, k));
        end

        // Reset falling in the middle of T4
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) IR_data = 32'h20000000;
            if (k < 4) begin
                push("midrst", model_word(5'b00100, k));
            end else begin
                check("midrst_t4", act(), model_word(5'b00100, 4));
                #1 Resetn = 1'b0;
                #1;
                check("midrst_zin",  {24'd0, Zin},  25'd0);
                check("midrst_rout", {24'd0, Rout}, 25'd0);
                check("midrst_op",   {20'd0, operation}, 25'd0);
                push("midrst_reset", 25'd0);
            end
        end
        tick();
        Resetn = 1'b1;
        push("midrst_reset", 25'd0);
        do_instr("final", 32'h50000000, -1);

        @(negedge Clock);
        #1;
        if (exp_q.size() != 0) check("queue_drained", 25'(exp_q.size()), 25'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
